// File: rtl/dcache_ctrl.sv
// Data-cache controller: decodes MEM-stage loads/stores into SRAM block accesses,
// answers hits in the request cycle, and on a miss stalls, writes back a dirty
// victim, refills the block from memory and replays the access.
module dcache_ctrl #(
  parameter int unsigned TAG_W    = 23,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned BLK_BITS = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_ren,
  input  logic                   cpu_wen,
  input  logic [31:0]            cpu_addr,
  input  logic [1:0]             cpu_size,
  input  logic [31:0]            cpu_wdata,
  output logic [31:0]            cpu_rdata,
  output logic                   stall,
  output logic                   misaligned,
  output logic                   sram_en,
  output logic                   sram_wen,
  output logic                   sram_memWen,
  output logic [15:0]            sram_bytesAccess,
  output logic [TAG_W+IDX_W-1:0] sram_blockAddr,
  output logic [BLK_BITS-1:0]    sram_dataIn,
  input  logic                   sram_hit,
  input  logic                   sram_dirtyBit,
  input  logic [BLK_BITS-1:0]    sram_dataOut,
  input  logic [TAG_W-1:0]       sram_victimTag,
  input  logic [BLK_BITS-1:0]    sram_victimData,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [TAG_W+IDX_W-1:0] mem_addr,
  output logic [BLK_BITS-1:0]    mem_wdata,
  input  logic                   mem_ready,
  input  logic [BLK_BITS-1:0]    mem_rdata,
  output logic [15:0]            hit_cnt,
  output logic [15:0]            miss_cnt
);

  localparam int unsigned BaW = TAG_W + IDX_W;

  typedef enum logic [1:0] {StIdle, StWb, StRefill} state_e;

  state_e                state_q;
  logic [BaW-1:0]        blk_q;
  logic [TAG_W-1:0]      vtag_q;
  logic [BLK_BITS-1:0]   vdata_q;
  logic                  replay_q;
  logic [15:0]           hit_cnt_q;
  logic [15:0]           miss_cnt_q;

  logic                  req;
  logic                  mis;
  logic                  access;
  logic [3:0]            off;
  logic [15:0]           base_mask;

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Request decode: size mask and alignment check.
  always_comb begin
    req = cpu_ren | cpu_wen;
    off = cpu_addr[3:0];
    unique case (cpu_size)
      2'd0:    base_mask = 16'h0001;
      2'd1:    base_mask = 16'h0003;
      default: base_mask = 16'h000F;
    endcase
    mis    = ((cpu_size == 2'd1) && cpu_addr[0]) ||
             (cpu_size[1] && (cpu_addr[1:0] != 2'b00));
    access = req && !mis;
  end

  // Miss FSM, victim/address latches, replay flag and performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      blk_q      <= '0;
      vtag_q     <= '0;
      vdata_q    <= '0;
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (access) begin
            replay_q <= 1'b0;
            if (sram_hit) begin
              // The lookup right after a refill is the replay, already counted as a miss.
              if (!replay_q) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
              miss_cnt_q <= miss_cnt_q + 16'd1;
              blk_q      <= cpu_addr[31:32-BaW];
              vtag_q     <= sram_victimTag;
              vdata_q    <= sram_victimData;
              state_q    <= sram_dirtyBit ? StWb : StRefill;
            end
          end
        end
        StWb: begin
          if (mem_ready) state_q <= StRefill;
        end
        StRefill: begin
          if (mem_ready) begin
            state_q  <= StIdle;
            replay_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // SRAM, memory-bus and pipeline outputs decoded from state and the live request.
  always_comb begin
    cpu_rdata        = req ? sram_dataOut[{off[3:2], 5'b0} +: 32] : 32'h0;
    stall            = 1'b0;
    misaligned       = 1'b0;
    sram_en          = 1'b0;
    sram_wen         = 1'b0;
    sram_memWen      = 1'b0;
    sram_bytesAccess = '0;
    sram_blockAddr   = '0;
    sram_dataIn      = '0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          misaligned = mis;
          if (!mis) begin
            sram_en          = 1'b1;
            sram_blockAddr   = cpu_addr[31:32-BaW];
            sram_dataIn      = {4{cpu_wdata}};
            sram_bytesAccess = cpu_wen ? (base_mask << off) : 16'h0000;
            sram_wen         = cpu_wen && sram_hit;
            stall            = !sram_hit;
          end
        end
      end
      StWb: begin
        stall          = 1'b1;
        sram_blockAddr = blk_q;
        mem_req        = 1'b1;
        mem_we         = 1'b1;
        mem_addr       = {vtag_q, blk_q[IDX_W-1:0]};
        mem_wdata      = vdata_q;
      end
      StRefill: begin
        stall          = 1'b1;
        sram_blockAddr = blk_q;
        sram_dataIn    = mem_rdata;
        mem_req        = 1'b1;
        mem_addr       = blk_q;
        // Install the block in the same cycle the memory answers; mask stays zero.
        if (mem_ready) begin
          sram_en     = 1'b1;
          sram_wen    = 1'b1;
          sram_memWen = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: a 2-way SRAM model and main memory surround the DUT; every
// access is checked against a flat golden memory and a per-access phase script.
module tb_dcache_ctrl;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_ren = 1'b0, cpu_wen = 1'b0;
  logic [31:0]   cpu_addr = '0;
  logic [1:0]    cpu_size = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [31:0]   cpu_rdata;
  logic          stall, misaligned, sram_en, sram_wen, sram_memWen;
  logic [15:0]   sram_bytesAccess;
  logic [27:0]   sram_blockAddr;
  logic [127:0]  sram_dataIn;
  logic          sram_hit = 1'b0, sram_dirtyBit = 1'b0;
  logic [127:0]  sram_dataOut = '0, sram_victimData = '0;
  logic [22:0]   sram_victimTag = '0;
  logic          mem_req, mem_we;
  logic [27:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic          mem_ready = 1'b0;
  logic [127:0]  mem_rdata = '0;
  logic [15:0]   hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall), .misaligned(misaligned),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_memWen(sram_memWen),
    .sram_bytesAccess(sram_bytesAccess), .sram_blockAddr(sram_blockAddr),
    .sram_dataIn(sram_dataIn), .sram_hit(sram_hit), .sram_dirtyBit(sram_dirtyBit),
    .sram_dataOut(sram_dataOut), .sram_victimTag(sram_victimTag),
    .sram_victimData(sram_victimData), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Environment: main memory indexed by blockAddr[7:0]; golden view of the address space.
  logic [127:0] mem  [256];
  logic [127:0] gold [256];
  // SRAM model: slot = set*2 + way; s_lru holds the way to evict next.
  logic [22:0]  s_tag [64];
  logic         s_val [64];
  logic         s_dty [64];
  logic [127:0] s_dat [64];
  logic         s_lru [32];

  int unsigned n_vec = 0, n_err = 0;
  logic [15:0] exp_hit = '0, exp_miss = '0;

  // Records of the most recent access, pinned against literals by the directed tests.
  int          rec_stall;
  logic [27:0] rec_wb_addr, rec_rf_addr;
  logic [15:0] rec_mask;
  logic [127:0] rec_din;
  logic [31:0] rec_rdata;
  logic        rec_mis;

  // Write command captured just before each clock edge.
  logic         c_en, c_wen, c_mwen, c_mreq, c_mwe, c_mrdy;
  logic [15:0]  c_mask;
  logic [127:0] c_din, c_mwd;
  logic [27:0]  c_ba, c_ma;

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int find_hit(input logic [27:0] b);
    for (int w = 0; w < 2; w++) begin
      if (s_val[int'(b[4:0])*2+w] && s_tag[int'(b[4:0])*2+w] == b[27:5]) return w;
    end
    return -1;
  endfunction

  function automatic int victim(input logic [4:0] set);
    if (!s_val[int'(set)*2]) return 0;
    if (!s_val[int'(set)*2+1]) return 1;
    return int'(s_lru[set]);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_ctl(input string ph, input logic e_stall, input logic e_en,
                         input logic e_wen, input logic e_mwen, input logic e_req,
                         input logic e_mis);
    chk({ph, ".stall"}, stall, e_stall);
    chk({ph, ".sram_en"}, sram_en, e_en);
    chk({ph, ".sram_wen"}, sram_wen, e_wen);
    chk({ph, ".sram_memWen"}, sram_memWen, e_mwen);
    chk({ph, ".mem_req"}, mem_req, e_req);
    chk({ph, ".misaligned"}, misaligned, e_mis);
    chk({ph, ".hit_cnt"}, hit_cnt, exp_hit);
    chk({ph, ".miss_cnt"}, miss_cnt, exp_miss);
  endtask

  // SRAM lookup for the current cpu_addr.
  task automatic drive_sram();
    int h, v, sl;
    h  = find_hit(cpu_addr[31:4]);
    v  = victim(cpu_addr[8:4]);
    sl = int'(cpu_addr[8:4]) * 2 + v;
    sram_hit        = (h >= 0);
    sram_dataOut    = (h >= 0) ? s_dat[int'(cpu_addr[8:4])*2+h] : rnd128();
    sram_victimTag  = s_tag[sl];
    sram_victimData = s_dat[sl];
    sram_dirtyBit   = s_val[sl] && s_dty[sl];
  endtask

  // Capture the DUT's commands, let the edge pass, then apply them to SRAM and memory.
  task automatic advance();
    int set, w, h, sl;
    c_en = sram_en; c_wen = sram_wen; c_mwen = sram_memWen; c_mask = sram_bytesAccess;
    c_din = sram_dataIn; c_ba = sram_blockAddr; c_mreq = mem_req; c_mwe = mem_we;
    c_mrdy = mem_ready; c_ma = mem_addr; c_mwd = mem_wdata;
    @(posedge clk);
    set = int'(c_ba[4:0]);
    if (c_en && c_wen && c_mwen) begin
      w = victim(c_ba[4:0]);
      sl = set * 2 + w;
      s_tag[sl] = c_ba[27:5]; s_dat[sl] = c_din; s_val[sl] = 1'b1; s_dty[sl] = 1'b0;
      s_lru[set] = (w == 0);
    end else if (c_en) begin
      h = find_hit(c_ba);
      if (h >= 0) begin
        sl = set * 2 + h;
        if (c_wen) begin
          for (int k = 0; k < 16; k++) if (c_mask[k]) s_dat[sl][k*8 +: 8] = c_din[k*8 +: 8];
          s_dty[sl] = 1'b1;
        end
        s_lru[set] = (h == 0);
      end
    end
    if (c_mreq && c_mwe && c_mrdy) mem[c_ma[7:0]] = c_mwd;
    @(negedge clk);
  endtask

  // One CPU access from presentation to completion; nw/nr are wait cycles before mem_ready.
  task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input int nw, input int nr);
    logic [27:0]  blk;
    logic [3:0]   off;
    logic         mis, replay, dirty;
    logic [15:0]  mask;
    logic [22:0]  vtag;
    logic [127:0] vdata, bd;
    logic [31:0]  eword;
    int           v, sl;
    cpu_ren = ren; cpu_wen = wen; cpu_addr = addr; cpu_size = size; cpu_wdata = wdata;
    mem_ready = 1'($urandom_range(0, 1));  // ignored outside a memory transaction
    mem_rdata = rnd128();
    drive_sram();
    #1;
    blk = addr[31:4];
    off = addr[3:0];
    mis = (size == 2'd1 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
    rec_stall = 0;
    if (!ren && !wen) begin
      chk_ctl("idle", 0, 0, 0, 0, 0, 0);
      chk("idle.cpu_rdata", cpu_rdata, 0);
      advance();
      return;
    end
    if (mis) begin
      chk_ctl("misal", 0, 0, 0, 0, 0, 1);
      rec_mis = misaligned;
      advance();
      return;
    end
    replay = 1'b0;
    if (find_hit(blk) < 0) begin
      v = victim(blk[4:0]);
      sl = int'(blk[4:0]) * 2 + v;
      vtag = s_tag[sl]; vdata = s_dat[sl]; dirty = s_val[sl] && s_dty[sl];
      chk_ctl("miss", 1, 1, 0, 0, 0, 0);
      chk("miss.blockAddr", sram_blockAddr, blk);
      rec_stall++;
      exp_miss++;
      advance();
      if (dirty) begin
        for (int c = 0; c <= nw; c++) begin
          mem_ready = (c == nw); mem_rdata = rnd128();
          #1;
          chk_ctl("wb", 1, 0, 0, 0, 1, 0);
          chk("wb.mem_we", mem_we, 1);
          chk("wb.mem_addr", mem_addr, {vtag, blk[4:0]});
          chk("wb.mem_wdata", mem_wdata, vdata);
          if (c == 0) rec_wb_addr = mem_addr;
          rec_stall++;
          advance();
        end
      end
      for (int c = 0; c <= nr; c++) begin
        mem_ready = (c == nr);
        mem_rdata = (c == nr) ? mem[blk[7:0]] : rnd128();
        #1;
        chk_ctl("refill", 1, c == nr, c == nr, c == nr, 1, 0);
        chk("refill.mem_we", mem_we, 0);
        chk("refill.mem_addr", mem_addr, blk);
        if (c == nr) begin
          chk("refill.bytesAccess", sram_bytesAccess, 0);
          chk("refill.dataIn", sram_dataIn, mem[blk[7:0]]);
          chk("refill.blockAddr", sram_blockAddr, blk);
        end
        if (c == 0) rec_rf_addr = mem_addr;
        rec_stall++;
        advance();
      end
      replay = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
      drive_sram();
      #1;
    end
    bd    = gold[blk[7:0]];
    eword = bd[off[3:2]*32 +: 32];
    mask  = ((size == 2'd0) ? 16'h0001 : (size == 2'd1) ? 16'h0003 : 16'h000F) << off;
    chk_ctl(replay ? "replay" : "hit", 0, 1, wen, 0, 0, 0);
    chk("hit.cpu_rdata", cpu_rdata, eword);
    chk("hit.blockAddr", sram_blockAddr, blk);
    if (wen) begin
      chk("hit.bytesAccess", sram_bytesAccess, mask);
      chk("hit.dataIn", sram_dataIn, {4{wdata}});
      for (int k = 0; k < 16; k++) if (mask[k]) gold[blk[7:0]][k*8 +: 8] = wdata[(k%4)*8 +: 8];
    end
    rec_rdata = cpu_rdata; rec_mask = sram_bytesAccess; rec_din = sram_dataIn;
    if (!replay) exp_hit++;
    advance();
  endtask

  // Install a line directly in the SRAM model, keeping the golden view consistent.
  task automatic preload(input logic [4:0] set, input int way, input logic [22:0] tag,
                         input logic dty);
    int sl;
    logic [7:0] bi;
    sl = int'(set) * 2 + way;
    bi = {tag[2:0], set};
    s_tag[sl] = tag; s_val[sl] = 1'b1; s_dty[sl] = dty;
    s_dat[sl] = dty ? rnd128() : mem[bi];
    gold[bi]  = s_dat[sl];
  endtask

  task automatic pulse_reset();
    #2;
    rst = 1'b0; cpu_ren = 1'b0; cpu_wen = 1'b0;
    exp_hit = '0; exp_miss = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  o;
    logic [1:0]  sz;
    int          r;
    for (int i = 0; i < 256; i++) begin mem[i] = rnd128(); gold[i] = mem[i]; end
    for (int i = 0; i < 64; i++) begin
      s_tag[i] = '0; s_val[i] = 1'b0; s_dty[i] = 1'b0; s_dat[i] = '0;
    end
    for (int i = 0; i < 32; i++) s_lru[i] = 1'b0;

    // Reset state.
    #2;
    chk("reset.stall", stall, 0);
    chk("reset.sram_en", sram_en, 0);
    chk("reset.mem_req", mem_req, 0);
    chk("reset.hit_cnt", hit_cnt, 16'h0000);
    chk("reset.miss_cnt", miss_cnt, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // Clean miss then replay hit.
    mem[8'h10][63:32] = 32'hDEADBEEF;
    gold[8'h10] = mem[8'h10];
    access(1, 0, 32'h0000_0104, 2'd2, 32'h0, 0, 3);
    chk("clean.stall_cycles", rec_stall, 5);
    chk("clean.mem_addr", rec_rf_addr, 28'h10);
    chk("clean.cpu_rdata", rec_rdata, 32'hDEADBEEF);
    chk("clean.miss_cnt", miss_cnt, 16'd1);
    chk("clean.hit_cnt", hit_cnt, 16'd0);

    // Store masks on hits.
    access(0, 1, 32'h0000_0106, 2'd1, 32'h1234_5678, 0, 0);
    chk("mask.half", rec_mask, 16'h00C0);
    chk("mask.half_stall", rec_stall, 0);
    access(0, 1, 32'h0000_010C, 2'd2, 32'hCAFE_F00D, 0, 0);
    chk("mask.word", rec_mask, 16'hF000);
    access(0, 1, 32'h0000_010F, 2'd0, 32'h5A5A_5A5A, 0, 0);
    chk("mask.byte", rec_mask, 16'h8000);

    // Misaligned accesses.
    access(1, 0, 32'h0000_0102, 2'd2, 32'h0, 0, 0);
    chk("misal.word", rec_mis, 1);
    access(1, 0, 32'h0000_0105, 2'd1, 32'h0, 0, 0);
    chk("misal.half", rec_mis, 1);

    // Dirty miss: victim tag 7 in set 0.
    preload(5'd0, 0, 23'd7, 1'b1);
    preload(5'd0, 1, 23'd5, 1'b0);
    s_lru[0] = 1'b0;
    access(0, 1, 32'h0000_0203, 2'd0, 32'hABAB_ABAB, 2, 1);
    chk("dirty.wb_addr", rec_wb_addr, 28'hE0);
    chk("dirty.rf_addr", rec_rf_addr, 28'h20);
    chk("dirty.mask", rec_mask, 16'h0008);
    chk("dirty.lane0", rec_din[31:0], 32'hABABABAB);

    // Reset while in writeback.
    preload(5'd2, 0, 23'd6, 1'b1);
    preload(5'd2, 1, 23'd5, 1'b0);
    s_lru[2] = 1'b0;
    cpu_ren = 1'b0; cpu_wen = 1'b1; cpu_addr = 32'h0000_0220; cpu_size = 2'd2;
    cpu_wdata = 32'h1111_2222; mem_ready = 1'b0;
    drive_sram();
    #1;
    chk("rwb.miss_stall", stall, 1);
    exp_miss++;
    advance();
    repeat (2) begin
      mem_ready = 1'b0;
      #1;
      chk("rwb.in_wb", mem_req, 1);
      advance();
    end
    #2;
    rst = 1'b0; cpu_wen = 1'b0;
    exp_hit = '0; exp_miss = '0;
    #1;
    chk("rwb.mem_req", mem_req, 0);
    chk("rwb.stall", stall, 0);
    chk("rwb.hit_cnt", hit_cnt, 16'h0000);
    chk("rwb.miss_cnt", miss_cnt, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    access(0, 0, 32'h0, 2'd0, 32'h0, 0, 0);
    access(1, 0, 32'h0000_0220, 2'd2, 32'h0, 1, 1);

    // Randomized traffic over a small, conflict-heavy address space.
    for (int i = 0; i < 600; i++) begin
      r  = $urandom_range(0, 7);
      sz = 2'($urandom_range(0, 3));
      o  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) o[0] = 1'b0;
        else if (sz[1]) o[1:0] = 2'b00;
      end
      a = {21'd0, 2'($urandom_range(0, 3)), 3'd0, 2'($urandom_range(0, 3)), o};
      access((r >= 1 && r <= 4) || r == 7, r >= 5, a, sz, $urandom(),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Counter wrap on a resident block.
    access(1, 0, 32'h0000_0104, 2'd2, 32'h0, 0, 0);
    pulse_reset();
    for (int i = 0; i < 65535; i++) access(1, 0, 32'h0000_0104, 2'd2, 32'h0, 0, 0);
    chk("wrap.ffff", hit_cnt, 16'hFFFF);
    access(1, 0, 32'h0000_0108, 2'd2, 32'h0, 0, 0);
    chk("wrap.zero", hit_cnt, 16'h0000);
    chk("wrap.miss_cnt", miss_cnt, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
